ddr_wr_burst_master: RTL and testbench
======================================

Name: ddr_wr_burst_master

Overview:
- Write-side front end for the DDR3 controller's AXI-like write port.
- Accepts a stream of 256-bit words (8×MEM_DQ_WIDTH) from the video/capture pipeline and buffers them in an internal FIFO.
- Issues fixed-length write bursts: awvalid/awready address handshake, then data supplied beat-by-beat on axi_wready.
- Walks a circular frame region in DDR and restarts at the base address on each frame start.

Parameters:
- MEM_DQ_WIDTH, 32, DDR data width; beat width is 8×MEM_DQ_WIDTH = 256.
- CTRL_ADDR_WIDTH, 28, controller address width.
- BURST_LEN, 16, beats per burst (1..16); axi_awlen = BURST_LEN-1.
- ADDR_STEP, 8, address increment per beat in controller address units.
- BASE_ADDR, 0, first address of the frame region.
- FRAME_BEATS, 1024, region size in beats; must be a multiple of BURST_LEN.
- FIFO_DEPTH, 64, buffer depth in beats; power of 2, ≥ 2×BURST_LEN.

Ports:
- ddrphy_clkin  in  1  controller user clock; all logic on its rising edge.
- resetn  in  1  asynchronous active-low reset.
- ddr_init_done  in  1  controller ready; no AW is issued while low.
- frame_start  in  1  one-cycle pulse; the next burst begins at BASE_ADDR.
- in_valid  in  1  input word valid.
- in_data  in  8×MEM_DQ_WIDTH  input word.
- in_ready  out  1  high when FIFO not full.
- axi_awaddr  out  CTRL_ADDR_WIDTH  burst start address.
- axi_awuser_ap  out  1  constant 0.
- axi_awuser_id  out  4  constant 0.
- axi_awlen  out  4  constant BURST_LEN-1.
- axi_awvalid  out  1  address valid.
- axi_awready  in  1  address accepted.
- axi_wdata  out  8×MEM_DQ_WIDTH  FIFO head word.
- axi_wstrb  out  MEM_DQ_WIDTH  constant all ones.
- axi_wready  in  1  controller consumes axi_wdata this cycle.
- axi_wusero_last  in  1  controller marks last beat.
- busy  out  1  state ≠ IDLE/WAIT.
- fifo_level  out  log2(FIFO_DEPTH)+1  beats stored.
- last_err  out  1  sticky; set on last/beat-count mismatch.

Behaviour:
- Reset (async, resetn=0): state=IDLE, FIFO empty, addr=BASE_ADDR, beat_cnt=0, frame_pending=0.
  - Outputs: axi_awvalid=0, in_ready=0, busy=0, last_err=0, fifo_level=0.
  - in_ready may rise no earlier than the first clock after reset deassert.
- FIFO:
  - Write when in_valid&&in_ready; read when axi_wready in state DATA.
  - Simultaneous read and write in the same cycle leave the level unchanged.
  - in_ready = level<FIFO_DEPTH; input is never dropped.
  - axi_wdata is the combinational head word, valid the same cycle as axi_wready (zero-latency pull).
- State machine:
  - IDLE: go to WAIT when ddr_init_done=1.
  - WAIT: if frame_pending, set addr=BASE_ADDR and clear frame_pending. Then if level ≥ BURST_LEN, go to ADDR.
  - ADDR: axi_awvalid=1, holding axi_awaddr=addr stable. On axi_awready, go to DATA with beat_cnt=0.
  - DATA: each axi_wready pops one beat and increments beat_cnt. When beat_cnt reaches BURST_LEN-1 with axi_wready: addr += BURST_LEN×ADDR_STEP, wrapping to BASE_ADDR when it reaches BASE_ADDR+FRAME_BEATS×ADDR_STEP; then go to WAIT.
- Full-burst-before-AW rule: AW is never issued unless a full burst is already in the FIFO, so the FIFO cannot underflow during DATA.
  - If axi_wready arrives with the FIFO empty (protocol violation), do not pop and set last_err.
- last check: if axi_wusero_last=1 with axi_wready on a beat other than BURST_LEN-1, set last_err. Completion is still counted locally.
- frame_start:
  - Sets frame_pending in any state; it applies only at the next WAIT, so bursts are never split.
  - frame_start in the same cycle as a wrap: BASE_ADDR results either way.
- ddr_init_done falling mid-burst does not abort the burst. The FSM returns to IDLE after the burst completes.
- Latency: the first AW is asserted 2 cycles after the BURST_LEN-th word is written, given init_done=1.

Test Plan:
- Reset then init_done=1; push 16 words D0..D15 -> awvalid at cycle 2 after the 16th word, awaddr=0, awlen=15. With wready held high, wdata=D0..D15 over 16 cycles, then state WAIT, fifo_level=0.
- Push 1024 beats continuously with random awready/wready stalls -> 64 bursts at addresses 0,128,…,8064; the 65th burst's awaddr=0 (wrap). Data order is preserved and in_ready never drops data.
- frame_start pulsed mid-burst at addr 256 -> current burst completes at 256; the next awaddr=0.
- Hold wready=0 with continuous input -> level reaches 64, in_ready=0, no word lost. Releasing wready resumes in order.
- Assert wusero_last on beat 7 of 16 -> last_err=1 and stays set. The burst still ends after 16 beats.
- Assert resetn=0 mid-DATA -> awvalid=0, level=0, addr=BASE_ADDR immediately (asynchronously).

Source files
------------

// File: rtl/ddr_wr_burst_master_if.sv
// AXI-like write address/data channel between the burst master and the DDR controller.
interface ddr_wr_burst_master_if #(
  parameter int MEM_DQ_WIDTH    = 32,
  parameter int CTRL_ADDR_WIDTH = 28
);
  logic [CTRL_ADDR_WIDTH-1:0]  axi_awaddr;
  logic                        axi_awuser_ap;
  logic [3:0]                  axi_awuser_id;
  logic [3:0]                  axi_awlen;
  logic                        axi_awvalid;
  logic                        axi_awready;
  logic [8*MEM_DQ_WIDTH-1:0]   axi_wdata;
  logic [MEM_DQ_WIDTH-1:0]     axi_wstrb;
  logic                        axi_wready;
  logic                        axi_wusero_last;

  modport master (
    output axi_awaddr, axi_awuser_ap, axi_awuser_id, axi_awlen, axi_awvalid,
    output axi_wdata, axi_wstrb,
    input  axi_awready, axi_wready, axi_wusero_last
  );

  modport slave (
    input  axi_awaddr, axi_awuser_ap, axi_awuser_id, axi_awlen, axi_awvalid,
    input  axi_wdata, axi_wstrb,
    output axi_awready, axi_wready, axi_wusero_last
  );
endinterface

// File: rtl/ddr_wr_burst_master.sv
// Write-side burst master: buffers input words in a FIFO and issues fixed-length
// write bursts over a circular frame region, restarting at the base on frame start.
module ddr_wr_burst_master #(
  parameter int MEM_DQ_WIDTH    = 32,
  parameter int CTRL_ADDR_WIDTH = 28,
  parameter int BURST_LEN       = 16,
  parameter int ADDR_STEP       = 8,
  parameter int BASE_ADDR       = 0,
  parameter int FRAME_BEATS     = 1024,
  parameter int FIFO_DEPTH      = 64
) (
  input  logic                          ddrphy_clkin,
  input  logic                          resetn,
  input  logic                          ddr_init_done,
  input  logic                          frame_start,
  input  logic                          in_valid,
  input  logic [8*MEM_DQ_WIDTH-1:0]     in_data,
  output logic                          in_ready,
  ddr_wr_burst_master_if.master         axi,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          last_err
);
  localparam int DW   = 8 * MEM_DQ_WIDTH;
  localparam int LW   = $clog2(FIFO_DEPTH);
  localparam int LVLW = LW + 1;

  localparam logic [CTRL_ADDR_WIDTH-1:0] BASE     = CTRL_ADDR_WIDTH'(BASE_ADDR);
  localparam logic [CTRL_ADDR_WIDTH-1:0] STRIDE   = CTRL_ADDR_WIDTH'(BURST_LEN * ADDR_STEP);
  localparam logic [CTRL_ADDR_WIDTH-1:0] ADDR_END = CTRL_ADDR_WIDTH'(BASE_ADDR + FRAME_BEATS * ADDR_STEP);
  localparam logic [3:0]                 LAST_BEAT = 4'(BURST_LEN - 1);
  localparam logic [LW:0]                BURST_LVL = LVLW'(BURST_LEN);
  localparam logic [LW:0]                FULL_LVL  = LVLW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ADDR, S_DATA} state_t;

  state_t                     r_state;
  logic [DW-1:0]              r_mem [FIFO_DEPTH];
  logic [LW:0]                r_wptr, r_rptr;
  logic                       r_in_ready, r_awvalid, r_busy, r_last_err, r_frame_pend;
  logic [CTRL_ADDR_WIDTH-1:0] r_addr;
  logic [3:0]                 r_beat;

  logic                       w_wr, w_pull, w_rd, w_fp;
  logic [LW:0]                w_level, w_level_next;
  logic [CTRL_ADDR_WIDTH-1:0] w_addr_next;

  // FIFO handshakes, next level and the wrapped next-burst address
  always_comb begin
    w_level      = r_wptr - r_rptr;
    w_wr         = in_valid & r_in_ready;
    w_pull       = (r_state == S_DATA) & axi.axi_wready;
    w_rd         = w_pull & (w_level != '0);
    w_level_next = w_level + LVLW'(w_wr) - LVLW'(w_rd);
    w_fp         = r_frame_pend | frame_start;
    w_addr_next  = r_addr + STRIDE;
    if (w_addr_next == ADDR_END) w_addr_next = BASE;
  end

  // FIFO storage (no reset needed on the data array)
  always_ff @(posedge ddrphy_clkin) begin
    if (w_wr) r_mem[r_wptr[LW-1:0]] <= in_data;
  end

  // FIFO pointers; in_ready is registered from the next level so it stays low through reset
  always_ff @(posedge ddrphy_clkin or negedge resetn) begin
    if (!resetn) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_in_ready <= 1'b0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      r_in_ready <= (w_level_next < FULL_LVL);
    end
  end

  // Burst FSM with registered awvalid/busy, address walk, frame restart and last checking
  always_ff @(posedge ddrphy_clkin or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_addr       <= BASE;
      r_beat       <= '0;
      r_awvalid    <= 1'b0;
      r_busy       <= 1'b0;
      r_last_err   <= 1'b0;
      r_frame_pend <= 1'b0;
    end else begin
      r_frame_pend <= w_fp;
      case (r_state)
        S_IDLE: begin
          if (ddr_init_done) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (!ddr_init_done) begin
            r_state <= S_IDLE;
          end else begin
            // a frame start seen this cycle is folded in here rather than a burst later
            if (w_fp) begin
              r_addr       <= BASE;
              r_frame_pend <= 1'b0;
            end
            if (w_level >= BURST_LVL) begin
              r_state   <= S_ADDR;
              r_awvalid <= 1'b1;
              r_busy    <= 1'b1;
            end
          end
        end
        S_ADDR: begin
          if (axi.axi_awready) begin
            r_state   <= S_DATA;
            r_awvalid <= 1'b0;
            r_beat    <= '0;
          end
        end
        S_DATA: begin
          if (w_pull) begin
            r_beat <= r_beat + 1'b1;
            if ((axi.axi_wusero_last && (r_beat != LAST_BEAT)) || (w_level == '0))
              r_last_err <= 1'b1;
            if (r_beat == LAST_BEAT) begin
              r_addr  <= w_addr_next;
              r_busy  <= 1'b0;
              r_state <= ddr_init_done ? S_WAIT : S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Output drive
  always_comb begin
    in_ready          = r_in_ready;
    busy              = r_busy;
    fifo_level        = w_level;
    last_err          = r_last_err;
    axi.axi_awaddr    = r_addr;
    axi.axi_awuser_ap = 1'b0;
    axi.axi_awuser_id = '0;
    axi.axi_awlen     = LAST_BEAT;
    axi.axi_awvalid   = r_awvalid;
    axi.axi_wdata     = r_mem[r_rptr[LW-1:0]];
    axi.axi_wstrb     = '1;
  end
endmodule

// File: tb/tb_ddr_wr_burst_master.sv
// Randomized bench for ddr_wr_burst_master with a queue-based behavioural model.
module tb_ddr_wr_burst_master;
  localparam int BL        = 16;
  localparam int STRIDE    = BL * 8;
  localparam int REGION    = 1024 * 8;
  localparam int DEPTH     = 64;

  logic         clk = 1'b0;
  logic         resetn;
  logic         ddr_init_done, frame_start, in_valid;
  logic [255:0] in_data;
  logic         in_ready, busy, last_err;
  logic [6:0]   fifo_level;

  ddr_wr_burst_master_if #(.MEM_DQ_WIDTH(32), .CTRL_ADDR_WIDTH(28)) axi_if ();

  ddr_wr_burst_master #(
    .MEM_DQ_WIDTH(32), .CTRL_ADDR_WIDTH(28), .BURST_LEN(16), .ADDR_STEP(8),
    .BASE_ADDR(0), .FRAME_BEATS(1024), .FIFO_DEPTH(64)
  ) dut (
    .ddrphy_clkin(clk), .resetn(resetn), .ddr_init_done(ddr_init_done),
    .frame_start(frame_start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .axi(axi_if), .busy(busy), .fifo_level(fifo_level),
    .last_err(last_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  logic [255:0] q[$];
  logic [27:0]  aw_log[$];
  int           rem = 0;
  bit           err = 1'b0;
  int           exp_addr = 0;
  bit           pend = 1'b0;
  int           since_rst = 0;

  function automatic void chk(string name, logic [255:0] act, logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [255:0] word(int i);
    logic [31:0] w;
    w = 32'hA5A50000 + 32'(i);
    return {8{w}};
  endfunction

  // compare process: checks DUT against the model, then advances the model by the coming edge
  always @(negedge clk) begin
    if (!resetn) begin
      chk("rst_awvalid", 256'(axi_if.axi_awvalid), 256'(0));
      chk("rst_level",   256'(fifo_level), 256'(0));
      chk("rst_busy",    256'(busy), 256'(0));
      chk("rst_in_ready", 256'(in_ready), 256'(0));
      chk("rst_last_err", 256'(last_err), 256'(0));
      chk("rst_awaddr",  256'(axi_if.axi_awaddr), 256'(0));
      q.delete(); rem = 0; err = 1'b0; exp_addr = 0; pend = 1'b0; since_rst = 0;
    end else begin
      chk("level", 256'(fifo_level), 256'(q.size()));
      if (since_rst > 0) chk("in_ready", 256'(in_ready), 256'(q.size() < DEPTH));
      chk("wstrb", 256'(axi_if.axi_wstrb), 256'(32'hFFFF_FFFF));
      chk("last_err", 256'(last_err), 256'(err));
      if (axi_if.axi_awvalid) begin
        chk("awaddr", 256'(axi_if.axi_awaddr), 256'(exp_addr));
        chk("awlen", 256'(axi_if.axi_awlen), 256'(BL - 1));
        chk("awuser", 256'({axi_if.axi_awuser_ap, axi_if.axi_awuser_id}), 256'(0));
        chk("aw_full_burst", 256'(q.size() >= BL), 256'(1));
        chk("aw_during_data", 256'(rem), 256'(0));
      end
      if (rem > 0) chk("busy_data", 256'(busy), 256'(1));
      else if (q.size() < BL) chk("busy_idle", 256'(busy), 256'(0));

      if (frame_start) pend = 1'b1;
      if (rem > 0 && axi_if.axi_wready) begin
        chk("pop_nonempty", 256'(q.size() != 0), 256'(1));
        if (q.size() != 0) begin
          chk("wdata", axi_if.axi_wdata, q[0]);
          void'(q.pop_front());
        end
        if (axi_if.axi_wusero_last && rem != 1) err = 1'b1;
        rem--;
        if (rem == 0) begin
          exp_addr = pend ? 0 : (((exp_addr + STRIDE) == REGION) ? 0 : exp_addr + STRIDE);
          pend = 1'b0;
        end
      end
      if (in_valid && in_ready) q.push_back(in_data);
      if (axi_if.axi_awvalid && axi_if.axi_awready) begin
        aw_log.push_back(axi_if.axi_awaddr);
        rem = BL;
      end
      since_rst++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    for (int j = 0; j < 8; j++) in_data[j*32 +: 32] = $urandom();
  endtask

  task automatic push_n(int n);
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < 200) begin
      in_valid = 1'b1;
      rand_data();
      if (in_ready) got++;
      step();
      cyc++;
    end
    in_valid = 1'b0;
    chk("push_count", 256'(got), 256'(n));
  endtask

  task automatic wait_aw();
    int cyc = 0;
    axi_if.axi_awready = 1'b1;
    while (rem == 0 && cyc < 50) begin
      step();
      cyc++;
    end
    axi_if.axi_awready = 1'b0;
    chk("aw_handshake", 256'(rem != 0), 256'(1));
  endtask

  // random traffic with stalls; optionally pulses frame_start mid-burst at a given address
  task automatic traffic(int n_words, int fs_addr, int max_cyc);
    int pushed = 0;
    int cyc = 0;
    bit fs_done = 1'b0;
    while ((pushed < n_words || q.size() != 0 || rem != 0) && cyc < max_cyc) begin
      in_valid = (pushed < n_words) && ($urandom_range(0, 9) < 8);
      rand_data();
      if (in_valid && in_ready) pushed++;
      axi_if.axi_awready     = ($urandom_range(0, 2) != 0);
      axi_if.axi_wready      = ($urandom_range(0, 3) != 0);
      axi_if.axi_wusero_last = axi_if.axi_wready && (rem == 1);
      frame_start = 1'b0;
      if (fs_addr >= 0 && !fs_done && rem == 8 && aw_log.size() != 0)
        if (aw_log[aw_log.size()-1] == 28'(fs_addr)) begin
          frame_start = 1'b1;
          fs_done = 1'b1;
        end
      step();
      cyc++;
    end
    in_valid = 1'b0; frame_start = 1'b0;
    axi_if.axi_awready = 1'b0; axi_if.axi_wready = 1'b0; axi_if.axi_wusero_last = 1'b0;
    chk("traffic_done_in_budget", 256'(cyc < max_cyc), 256'(1));
  endtask

  initial begin
    resetn = 1'b0; ddr_init_done = 1'b0; frame_start = 1'b0; in_valid = 1'b0; in_data = '0;
    axi_if.axi_awready = 1'b0; axi_if.axi_wready = 1'b0; axi_if.axi_wusero_last = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    chk("in_ready_before_clock", 256'(in_ready), 256'(0));
    step();
    ddr_init_done = 1'b1;
    step();

    // first burst: latency, address, data order with wready held high
    for (int i = 0; i < BL; i++) begin
      in_valid = 1'b1;
      in_data  = word(i);
      step();
    end
    in_valid = 1'b0;
    chk("t1_aw_lat1", 256'(axi_if.axi_awvalid), 256'(0));
    step();
    chk("t1_aw_lat2", 256'(axi_if.axi_awvalid), 256'(1));
    chk("t1_awaddr", 256'(axi_if.axi_awaddr), 256'(0));
    chk("t1_awlen", 256'(axi_if.axi_awlen), 256'(15));
    axi_if.axi_awready = 1'b1;
    step();
    axi_if.axi_awready = 1'b0;
    for (int i = 0; i < BL; i++) begin
      axi_if.axi_wready = 1'b1;
      axi_if.axi_wusero_last = (i == BL - 1);
      chk("t1_wdata", axi_if.axi_wdata, word(i));
      step();
    end
    axi_if.axi_wready = 1'b0; axi_if.axi_wusero_last = 1'b0;
    chk("t1_level", 256'(fifo_level), 256'(0));
    chk("t1_busy", 256'(busy), 256'(0));

    // full frame with stalls, then wrap to base
    traffic(1024, -1, 20000);
    chk("t2_aw_count", 256'(aw_log.size()), 256'(65));
    chk("t2_aw1", 256'(aw_log[1]), 256'(128));
    chk("t2_aw63", 256'(aw_log[63]), 256'(8064));
    chk("t2_aw64_wrap", 256'(aw_log[64]), 256'(0));

    // frame_start in the middle of the burst at 256
    traffic(48, 256, 3000);
    chk("t3_aw65", 256'(aw_log[65]), 256'(128));
    chk("t3_aw66", 256'(aw_log[66]), 256'(256));
    chk("t3_aw67_restart", 256'(aw_log[67]), 256'(0));

    // backpressure: FIFO fills with wready held low
    axi_if.axi_awready = 1'b1;
    axi_if.axi_wready  = 1'b0;
    for (int c = 0; c < 80; c++) begin
      in_valid = 1'b1;
      rand_data();
      step();
    end
    in_valid = 1'b0;
    axi_if.axi_awready = 1'b0;
    chk("t4_level_full", 256'(fifo_level), 256'(64));
    chk("t4_in_ready_low", 256'(in_ready), 256'(0));
    traffic(0, -1, 3000);
    chk("t4_last_aw", 256'(aw_log[aw_log.size()-1]), 256'(512));

    // early last on beat 7
    push_n(BL);
    wait_aw();
    for (int i = 0; i < BL; i++) begin
      axi_if.axi_wready = 1'b1;
      axi_if.axi_wusero_last = (i == 7);
      step();
    end
    axi_if.axi_wready = 1'b0; axi_if.axi_wusero_last = 1'b0;
    chk("t5_last_err", 256'(last_err), 256'(1));
    chk("t5_busy_after16", 256'(busy), 256'(0));
    chk("t5_level", 256'(fifo_level), 256'(0));

    // asynchronous reset in the middle of a burst
    push_n(BL);
    wait_aw();
    for (int i = 0; i < 5; i++) begin
      axi_if.axi_wready = 1'b1;
      step();
    end
    chk("t6_awaddr_pre", 256'(axi_if.axi_awaddr), 256'(768));
    chk("t6_last_err_sticky", 256'(last_err), 256'(1));
    #2 resetn = 1'b0;
    #1;
    axi_if.axi_wready = 1'b0;
    chk("t6_async_awvalid", 256'(axi_if.axi_awvalid), 256'(0));
    chk("t6_async_level", 256'(fifo_level), 256'(0));
    chk("t6_async_awaddr", 256'(axi_if.axi_awaddr), 256'(0));
    chk("t6_async_busy", 256'(busy), 256'(0));
    chk("t6_async_in_ready", 256'(in_ready), 256'(0));
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    step();
    step();

    // recovery after reset restarts at the base
    traffic(32, -1, 2000);
    chk("t7_aw_base", 256'(aw_log[74]), 256'(0));
    chk("t7_aw_next", 256'(aw_log[75]), 256'(128));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
